// File: rtl/tt_sweep_ctrl_if.sv
// Handshake and data bundle between the sweep controller, its CPU-side
// control registers and the combinational function under test.
//   start, abort    : sweep control from the register side
//   expected        : reference truth table
//   x_out / f_in    : vector driven to / result returned from the function
//   busy, done      : sweep status
//   tt, ones_cnt    : captured signature and onset size
//   match           : signature equals expected
interface tt_sweep_ctrl_if #(
   parameter int unsigned NUM_INPUTS = 7
);
   localparam int unsigned TT_W = 2 ** NUM_INPUTS;

   logic                  start;
   logic                  abort;
   logic [TT_W-1:0]       expected;
   logic [NUM_INPUTS-1:0] x_out;
   logic                  f_in;
   logic                  busy;
   logic                  done;
   logic [TT_W-1:0]       tt;
   logic [NUM_INPUTS:0]   ones_cnt;
   logic                  match;

   // Register side plus function under test.
   modport master (
      output start, abort, expected, f_in,
      input  x_out, busy, done, tt, ones_cnt, match
   );

   // Sweep controller.
   modport slave (
      input  start, abort, expected, f_in,
      output x_out, busy, done, tt, ones_cnt, match
   );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweeper for a single-output combinational block.
// Walks every input vector, holds each for SETTLE_CYCLES+1 cycles, samples
// the block output on the last cycle, builds the signature and its onset
// count, and compares against the expected table when the sweep ends.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tt_sweep_ctrl_if slave (control, vector out, result in, status)
module tt_sweep_ctrl #(
   parameter int unsigned NUM_INPUTS    = 7,
   parameter int unsigned SETTLE_CYCLES = 0
) (
   input logic           clk,
   input logic           rst_n,
   tt_sweep_ctrl_if.slave bus
);
   localparam int unsigned TT_W   = 2 ** NUM_INPUTS;
   localparam int unsigned IDX_W  = NUM_INPUTS;
   localparam int unsigned ONES_W = NUM_INPUTS + 1;
   localparam int unsigned CNT_W  = 4;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TT_W-1:0]     tt_q, tt_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic                match_q, match_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         tt_q    <= '0;
         ones_q  <= '0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         tt_q    <= tt_d;
         ones_q  <= ones_d;
         match_q <= match_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tt_d    = tt_q;
      ones_d  = ones_q;
      match_d = match_q;

      unique case (state_q)
         IDLE: begin
            // abort blocks a simultaneous start
            if (bus.start && !bus.abort) begin
               tt_d    = '0;
               ones_d  = '0;
               match_d = 1'b0;
               idx_d   = '0;
               cnt_d   = CNT_RELOAD;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               // partial tt/ones_cnt are kept for debug
               state_d = IDLE;
               match_d = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               tt_d[idx_q] = bus.f_in;
               ones_d      = ones_q + ONES_W'(bus.f_in);
               cnt_d       = CNT_RELOAD;
               if (idx_q == IDX_LAST) begin
                  // compare includes the sample taken on this edge
                  match_d = (tt_d == bus.expected);
                  idx_d   = '0;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags are registered copies of the upcoming state.
   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign bus.x_out    = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.tt       = tt_q;
   assign bus.ones_cnt = ones_q;
   assign bus.match    = match_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: table of sweeps on an S=0 instance with a
// scoreboard queue, plus hand sequences for settle timing (S=2 instance),
// abort, start/abort collision, start during RUN and mid-sweep reset.
module tb_tt_sweep_ctrl;
   localparam int unsigned NI   = 7;
   localparam int unsigned TT_W = 128;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tt_sweep_ctrl_if #(.NUM_INPUTS(NI)) bus0 ();
   tt_sweep_ctrl_if #(.NUM_INPUTS(NI)) bus2 ();

   tt_sweep_ctrl #(.NUM_INPUTS(NI), .SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   tt_sweep_ctrl #(.NUM_INPUTS(NI), .SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2)
   );

   // Reference function: the MAJ-network signature used as a lookup table.
   localparam logic [TT_W-1:0] MAJ_TT = 128'hfeeaeee8fae8e880fee8e8a0e888a880;
   localparam logic [TT_W-1:0] ALT_TT = {64{2'b10}};

   int mode;
   always_comb begin
      case (mode)
         0:       bus0.f_in = bus0.x_out[0];
         1:       bus0.f_in = 1'b0;
         2:       bus0.f_in = 1'b1;
         default: bus0.f_in = MAJ_TT[bus0.x_out];
      endcase
   end
   assign bus2.f_in = bus2.x_out[6];

   typedef struct {
      int              mode;
      logic [TT_W-1:0] expv;
      logic [TT_W-1:0] tt;
      int              ones;
      logic            match;
      int              done_cyc;
   } vec_t;

   vec_t vecs[5];
   vec_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [TT_W-1:0] act,
                        input logic [TT_W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Launch one sweep on dut0 and compare against the popped scoreboard
   // entry when done appears. mid_start>0 re-pulses start in that RUN cycle.
   task automatic run_sweep(input vec_t v, input int mid_start);
      vec_t e;
      int   c;
      mode          = v.mode;
      bus0.expected = v.expv;
      sb_q.push_back(v);
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      c = 1;
      check("busy_cycle1", TT_W'(bus0.busy), TT_W'(1));
      while (!bus0.done && c < 2000) begin
         bus0.start = (c == mid_start);
         @(negedge clk);
         c++;
      end
      bus0.start = 1'b0;
      e = sb_q.pop_front();
      check("done_cycle", TT_W'(c), TT_W'(e.done_cyc));
      check("tt", bus0.tt, e.tt);
      check("ones_cnt", TT_W'(bus0.ones_cnt), TT_W'(e.ones));
      check("match", TT_W'(bus0.match), TT_W'(e.match));
      check("busy_at_done", TT_W'(bus0.busy), TT_W'(0));
      @(negedge clk);
      check("done_one_cycle", TT_W'(bus0.done), TT_W'(0));
   endtask

   initial begin
      logic [TT_W-1:0] flipped;
      int c, holds_bad, seq_bad, hold, dones;
      logic [NI-1:0] prev_x;

      flipped = MAJ_TT;
      flipped[37] = ~flipped[37];
      vecs[0] = '{0, ALT_TT, ALT_TT, 64, 1'b1, 129};
      vecs[1] = '{1, '0, '0, 0, 1'b1, 129};
      vecs[2] = '{2, '0, '1, 128, 1'b0, 129};
      vecs[3] = '{3, MAJ_TT, MAJ_TT, $countones(MAJ_TT), 1'b1, 129};
      vecs[4] = '{3, flipped, MAJ_TT, $countones(MAJ_TT), 1'b0, 129};

      mode = 0;
      bus0.start = 1'b0; bus0.abort = 1'b0; bus0.expected = '0;
      bus2.start = 1'b0; bus2.abort = 1'b0; bus2.expected = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_x_out", TT_W'(bus0.x_out), TT_W'(0));
      check("rst_busy", TT_W'(bus0.busy), TT_W'(0));
      check("rst_done", TT_W'(bus0.done), TT_W'(0));
      check("rst_tt", bus0.tt, TT_W'(0));
      check("rst_ones", TT_W'(bus0.ones_cnt), TT_W'(0));
      check("rst_match", TT_W'(bus0.match), TT_W'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_sweep(vecs[i], 0);

      // Settle time 2: each vector held 3 cycles, upper half ones.
      @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      c = 1; hold = 1; holds_bad = 0; seq_bad = 0;
      prev_x = bus2.x_out;
      check("s2_first_x", TT_W'(bus2.x_out), TT_W'(0));
      while (!bus2.done && c < 2000) begin
         @(negedge clk);
         c++;
         if (bus2.busy) begin
            if (bus2.x_out == prev_x) hold++;
            else begin
               if (hold != 3) holds_bad++;
               if (bus2.x_out != prev_x + NI'(1)) seq_bad++;
               hold = 1;
            end
            prev_x = bus2.x_out;
         end
      end
      if (hold != 3) holds_bad++;
      check("s2_done_cycle", TT_W'(c), TT_W'(385));
      check("s2_hold_errs", TT_W'(holds_bad), TT_W'(0));
      check("s2_seq_errs", TT_W'(seq_bad), TT_W'(0));
      check("s2_last_x", TT_W'(prev_x), TT_W'(127));
      check("s2_tt", bus2.tt, {{64{1'b1}}, {64{1'b0}}});
      check("s2_ones", TT_W'(bus2.ones_cnt), TT_W'(64));

      // Abort at cycle 50.
      mode = 0; bus0.expected = ALT_TT;
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      c = 1;
      while (c < 50) begin @(negedge clk); c++; end
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.abort = 1'b0;
      check("abort_busy", TT_W'(bus0.busy), TT_W'(0));
      check("abort_match", TT_W'(bus0.match), TT_W'(0));
      check("abort_tt_partial", TT_W'(bus0.tt[1]), TT_W'(1));
      dones = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus0.done || bus0.busy) dones++;
      end
      check("abort_no_done", TT_W'(dones), TT_W'(0));

      // start and abort together in IDLE: nothing begins.
      bus0.start = 1'b1; bus0.abort = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0; bus0.abort = 1'b0;
      dones = 0;
      for (int k = 0; k < 5; k++) begin
         if (bus0.busy || bus0.done) dones++;
         @(negedge clk);
      end
      check("start_abort_idle", TT_W'(dones), TT_W'(0));

      // start during RUN is ignored.
      run_sweep(vecs[0], 30);

      // Mid-sweep reset at cycle 70.
      mode = 2; bus0.expected = '0;
      @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      c = 1;
      while (c < 70) begin @(negedge clk); c++; end
      check("pre_rst_tt_nonzero", TT_W'(bus0.tt != '0), TT_W'(1));
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", TT_W'(bus0.busy), TT_W'(0));
      check("arst_x_out", TT_W'(bus0.x_out), TT_W'(0));
      check("arst_tt", bus0.tt, TT_W'(0));
      check("arst_ones", TT_W'(bus0.ones_cnt), TT_W'(0));
      check("arst_done", TT_W'(bus0.done), TT_W'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(vecs[3], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
Sequencer that exhaustively characterises one combinational NUM_INPUTS-input Boolean function block, such as a majority-gate network with a single output.
- Drives every input vector 0..2^NUM_INPUTS-1 onto the block's inputs and samples its output after a programmable settle time.
- Assembles the truth-table signature and counts its onset.
- Compares the signature against an expected value and reports through a start/busy/done handshake.
- Sits in the classification test harness between the CPU-side control registers and the function under test.

Parameters:
- NUM_INPUTS, 7, number of function inputs; legal range 1..8; TT_W = 2**NUM_INPUTS.
- SETTLE_CYCLES, 0, extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel a sweep in progress.
- expected  in  TT_W  reference truth table; sampled only at sweep end.
- x_out  out  NUM_INPUTS  vector driven to the function under test; bit i = input xi.
- f_in  in  1  output of the function under test.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse on sweep completion.
- tt  out  TT_W  captured truth table; tt[k] = f(vector k).
- ones_cnt  out  NUM_INPUTS+1  number of vectors with f=1.
- match  out  1  tt equals expected; valid from the done pulse.

Behaviour:
- Asynchronous reset (rst_n low):
  - state=IDLE.
  - x_out=0, busy=0, done=0, tt=0, ones_cnt=0, match=0.
  - idx=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - x_out=0, busy=0.
  - If start=1 and abort=0: clear tt, ones_cnt and match; set idx=0, cnt=SETTLE_CYCLES, x_out=0; go to RUN.
  - If start=1 and abort=1 in the same cycle: abort wins and the block stays in IDLE.
- RUN:
  - busy=1; x_out=idx, registered.
  - If cnt!=0: cnt decrements.
  - If cnt==0: tt[idx] <= f_in; ones_cnt += f_in; cnt reloads to SETTLE_CYCLES.
    - If idx==TT_W-1: go to DONE, with match <= (final tt including this sample == expected).
    - Else idx increments and x_out follows on the same edge.
- Timing:
  - Each vector is held SETTLE_CYCLES+1 cycles and is sampled on its last cycle.
  - With start seen at edge 0, RUN occupies cycles 1..TT_W*(SETTLE_CYCLES+1).
  - done is high in cycle TT_W*(SETTLE_CYCLES+1)+1.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - tt, ones_cnt and match hold until the next accepted start.
- abort in RUN:
  - Next state is IDLE; busy drops on that edge; done is not pulsed.
  - match=0; tt and ones_cnt keep the partial values.
  - abort in IDLE or DONE has no effect beyond blocking start in IDLE.
- start while in RUN or DONE is ignored; it is not queued.
- No wrap-around: idx never exceeds TT_W-1; ones_cnt maximum is TT_W, which fits NUM_INPUTS+1 bits.
- rst_n asserted mid-sweep: immediate return to reset values; no done pulse.
- expected may change at any time; only its value in the final RUN cycle matters.
- Signature hex string is written MSB first, so tt[TT_W-1] is the leading nibble.

Test Plan:
1. NUM_INPUTS=7, S=0, f_in=x_out[0], start pulse at cycle 0:
   - done high exactly in cycle 129.
   - tt = 0xaaaa…aa (128 bits); ones_cnt = 64.
   - With expected = the same value, match = 1.
2. f_in tied to 0, then a second run with f_in tied to 1:
   - First run: tt = 0, ones_cnt = 0.
   - Second run: tt = all ones, ones_cnt = 128.
   - expected = 0 for both runs: match = 1 then 0.
3. f_in = MAJ-network model with expected = 0xfeeaeee8fae8e880fee8e8a0e888a880:
   - match = 1.
   - Flip one expected bit: match = 0.
4. S=2, f_in = x_out[6]:
   - Each x_out value is held exactly 3 cycles; done in cycle 385.
   - tt upper 64 bits are all ones, lower 64 bits all zero.
5. Abort at cycle 50 of a run:
   - busy = 0 at cycle 51; no done pulse; match = 0.
   - start in the same cycle as abort while IDLE: no run begins.
   - start during RUN: no effect on timing.
6. rst_n low at cycle 70 mid-sweep:
   - All outputs return to 0 asynchronously.
   - A subsequent start produces a complete, correct sweep.
